sc_upd_sched: RTL
=================

# sc_upd_sched

Update scheduler for the `sc_l` statistical-corrector table. It collects up to COMMIT_WIDTH resolved conditional-branch outcomes per cycle from commit and buffers them in order in a circular FIFO. It drains them one per cycle into `sc_l`'s single update port. It sits between the commit stage and `sc_l`, and is the only driver of `sc_l.update_*`.

## Interface
- `Cfg`, default `build_config(TestCfg)`: global `config_pkg::cfg_t`, carried for consistency with sibling predictor blocks.
- `COMMIT_WIDTH`, default 4: commit lanes per cycle.
- `GHR_BITS`, default 8: history width, equal to `sc_l.GHR_BITS`.
- `DEPTH`, default 8: FIFO entries; must be a power of two and ≥ COMMIT_WIDTH.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `commit_valid_i` in COMMIT_WIDTH: per-lane branch-resolved strobe; any bit pattern is legal.
- `commit_pc_i` in COMMIT_WIDTH×32: branch PC per lane.
- `commit_ghr_i` in COMMIT_WIDTH×GHR_BITS: history used at prediction time, per lane.
- `commit_taken_i` in COMMIT_WIDTH: resolved direction per lane.
- `commit_ready_o` out 1: free slots ≥ COMMIT_WIDTH.
- `hold_i` in 1: suppresses draining for this cycle.
- `update_valid_o` out 1: drives `sc_l.update_valid_i`.
- `update_pc_o` out 32: update PC.
- `update_ghr_o` out GHR_BITS: update history.
- `update_taken_o` out 1: update direction.
- `drop_cnt_o` out 16: dropped-update count. Present only with SC_UPD_PERF_EN.

## Operation
- Enqueue when `commit_ready_o`=1:
  - Valid lanes are compacted in ascending lane order. The lowest valid lane goes to `wr_ptr`, the next to `wr_ptr+1`, and so on.
  - `n_enq` = popcount(`commit_valid_i`).
- Enqueue when `commit_ready_o`=0: all valid lanes are discarded and the FIFO is untouched. Updates are hints, so commit never stalls on this block.
- `commit_ready_o` is combinational from the registered count only: `count ≤ DEPTH−COMMIT_WIDTH`.
- Dequeue:
  - `deq` = (`count`≠0) && !`hold_i`.
  - On the edge, the head entry is loaded into the output registers, `update_valid_o` is set, and `rd_ptr` advances.
  - If `deq`=0, `update_valid_o` clears and the data registers hold their values.
- Count arithmetic:
  - `count_next = count + n_enq − deq`.
  - `count` is `$clog2(DEPTH+1)` bits wide. It never exceeds DEPTH by construction of `commit_ready_o`.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH with no special case.
- Enqueue and dequeue in the same cycle are legal at every occupancy, including `count`=0 (enqueued entries are not bypassed) and `count`=DEPTH−COMMIT_WIDTH.
- There is no flush input. Committed outcomes are architecturally final and always drain.

## Timing
- Reset values:
  - `update_valid_o`=0, `update_pc_o`=0, `update_ghr_o`=0, `update_taken_o`=0.
  - `count`=0, both pointers 0.
  - `commit_ready_o`=1, `drop_cnt_o`=0.
- Latency:
  - A branch committed in cycle t into an empty FIFO appears on `update_*` in cycle t+2.
  - Sustained throughput is one update per cycle.
- `hold_i` asserted in cycle t means no new entry is presented in t+1. Entries are never lost while holding.
- Reset mid-operation: queued entries are discarded immediately and asynchronously, and outputs go to their reset values without waiting for a clock.

## Configuration
- SC_UPD_PERF_EN defined:
  - `drop_cnt_o` exists.
  - It increments by popcount(`commit_valid_i`) in each cycle where `commit_ready_o`=0.
  - It saturates at 16'hFFFF.
- SC_UPD_PERF_EN undefined: the port and counter are absent, and drop behaviour is otherwise identical.

## Structure
- Shared package `sc_pkg`:
  - `sc_upd_t` packed struct {pc[31:0], ghr[GHR_BITS-1:0], taken}.
  - The drop counter width constant `SC_DROP_CNT_W`=16.
- Sub-module `sc_upd_compact`: combinational prefix-popcount. It maps each valid lane to its slot offset and outputs `n_enq`.
- The FIFO storage is a flop array of `sc_upd_t` in the top module.

## Test plan
- Single branch: lane 0 valid, pc=0x8000_0010, taken=1, in cycle 5 → `update_valid_o`=1 with pc=0x8000_0010 only in cycle 7.
- Sparse lanes: valid=4'b1010 with pcs A,B,C,D → updates B then D in consecutive cycles; `count` returns to 0.
- Fill:
  - Three full 4-lane commits with `hold_i`=1 → `commit_ready_o` drops after 2 commits; the 3rd commit's 4 entries are dropped; `drop_cnt_o`=4 (PERF_EN).
  - Releasing hold → exactly 8 updates, in order.
- Wrap: 40 cycles of random valid patterns with random `hold_i` → update stream matches a reference queue exactly, pointers wrap ≥4 times, and there are no drops while `commit_ready_o`=1.
- Reset mid-drain: assert `rst_i` with 5 entries queued → `update_valid_o`=0 asynchronously; after release, no stale update appears.
- Saturation (PERF_EN): force 65 540 dropped lanes → `drop_cnt_o` holds at 16'hFFFF.

Source files
------------

// File: rtl/config_pkg.sv
// Global predictor configuration shared by the sibling branch-predictor blocks.
package config_pkg;

  typedef struct packed {
    logic [31:0] ghr_bits;
    logic [31:0] commit_width;
  } cfg_t;

  localparam cfg_t TestCfg = '{ghr_bits: 32'd8, commit_width: 32'd4};

  function automatic cfg_t build_config(input cfg_t base);
    cfg_t c;
    c = base;
    if (c.ghr_bits == 32'd0) c.ghr_bits = 32'd8;
    if (c.commit_width == 32'd0) c.commit_width = 32'd4;
    return c;
  endfunction

endpackage

// File: rtl/sc_pkg.sv
// Types shared between the statistical-corrector table and its update scheduler.
package sc_pkg;

  localparam int SC_GHR_BITS   = 8;
  localparam int SC_DROP_CNT_W = 16;

  typedef struct packed {
    logic [31:0]            pc;
    logic [SC_GHR_BITS-1:0] ghr;
    logic                   taken;
  } sc_upd_t;

endpackage

// File: rtl/sc_upd_compact.sv
// Prefix popcount over the commit lanes: slot offset of each valid lane plus total count.
module sc_upd_compact #(
  parameter int COMMIT_WIDTH = 4,
  parameter int OFF_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0]            i_valid,
  output logic [COMMIT_WIDTH-1:0][OFF_W-1:0] o_off,
  output logic [OFF_W-1:0]                   o_n_enq
);

  logic [OFF_W-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    o_off = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      o_off[i] = w_acc;
      w_acc    = w_acc + OFF_W'(i_valid[i]);
    end
    o_n_enq = w_acc;
  end

endmodule

// File: rtl/sc_upd_sched.sv
// In-order commit-to-sc_l update scheduler: compacting circular FIFO, one drain per cycle.
// Optional drop counter output enabled by defining SC_UPD_PERF_EN.
module sc_upd_sched
  import sc_pkg::*;
#(
  parameter config_pkg::cfg_t Cfg = config_pkg::build_config(config_pkg::TestCfg),
  parameter int COMMIT_WIDTH = 4,
  parameter int GHR_BITS     = int'(Cfg.ghr_bits),
  parameter int DEPTH        = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [COMMIT_WIDTH-1:0]             commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0][31:0]       commit_pc_i,
  input  logic [COMMIT_WIDTH-1:0][GHR_BITS-1:0] commit_ghr_i,
  input  logic [COMMIT_WIDTH-1:0]             commit_taken_i,
  output logic                                commit_ready_o,
  input  logic                                hold_i,
  output logic                                update_valid_o,
  output logic [31:0]                         update_pc_o,
  output logic [GHR_BITS-1:0]                 update_ghr_o,
  output logic                                update_taken_o
`ifdef SC_UPD_PERF_EN
  ,
  output logic [SC_DROP_CNT_W-1:0]            drop_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OFF_W = $clog2(COMMIT_WIDTH + 1);

  sc_upd_t                           r_mem [DEPTH];
  logic    [PTR_W-1:0]               r_wr_ptr;
  logic    [PTR_W-1:0]               r_rd_ptr;
  logic    [CNT_W-1:0]               r_count;

  logic    [COMMIT_WIDTH-1:0][OFF_W-1:0] w_off;
  logic    [OFF_W-1:0]               w_n_enq;
  logic    [CNT_W-1:0]               w_n_acc;
  logic                              w_deq;
  sc_upd_t                           w_entry [COMMIT_WIDTH];

  sc_upd_compact #(
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .OFF_W       (OFF_W)
  ) u_compact (
    .i_valid (commit_valid_i),
    .o_off   (w_off),
    .o_n_enq (w_n_enq)
  );

  // Ready depends only on registered occupancy so commit sees no combinational path from hold.
  assign commit_ready_o = (r_count <= CNT_W'(DEPTH - COMMIT_WIDTH));
  assign w_deq          = (r_count != '0) && !hold_i;
  assign w_n_acc        = commit_ready_o ? CNT_W'(w_n_enq) : '0;

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_entry[i] = '{pc: commit_pc_i[i], ghr: commit_ghr_i[i], taken: commit_taken_i[i]};
    end
  end

  // Storage carries no reset; only occupancy decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (commit_ready_o) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (commit_valid_i[i]) r_mem[r_wr_ptr + PTR_W'(w_off[i])] <= w_entry[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      update_valid_o <= 1'b0;
      update_pc_o    <= '0;
      update_ghr_o   <= '0;
      update_taken_o <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_acc);
      r_count  <= r_count + w_n_acc - CNT_W'(w_deq);
      if (w_deq) begin
        update_valid_o <= 1'b1;
        update_pc_o    <= r_mem[r_rd_ptr].pc;
        update_ghr_o   <= r_mem[r_rd_ptr].ghr;
        update_taken_o <= r_mem[r_rd_ptr].taken;
        r_rd_ptr       <= r_rd_ptr + PTR_W'(1);
      end else begin
        update_valid_o <= 1'b0;
      end
    end
  end

`ifdef SC_UPD_PERF_EN
  localparam int DROP_SUM_W = SC_DROP_CNT_W + 1;

  logic [SC_DROP_CNT_W-1:0] r_drop_cnt;

  function automatic logic [SC_DROP_CNT_W-1:0] sat_add(input logic [SC_DROP_CNT_W-1:0] a,
                                                       input logic [OFF_W-1:0] b);
    logic [DROP_SUM_W-1:0] s;
    s = {1'b0, a} + DROP_SUM_W'(b);
    return s[SC_DROP_CNT_W] ? '1 : s[SC_DROP_CNT_W-1:0];
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_drop_cnt <= '0;
    else if (!commit_ready_o) r_drop_cnt <= sat_add(r_drop_cnt, w_n_enq);
  end

  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule
